// File: rtl/mdio_pkg.sv
// mdio_pkg: clause-22 MDIO frame constants, field boundaries and responder state encoding.
package mdio_pkg;
   localparam logic [1:0] ST       = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam int         DATA_W   = 16;
   localparam logic [4:0] OP_END    = 5'd3;
   localparam logic [4:0] PHYAD_END = 5'd8;
   localparam logic [4:0] REGAD_END = 5'd13;
   localparam logic [4:0] TA_FIRST  = 5'd14;
   localparam logic [4:0] FRAME_END = 5'd31;
   typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, DATA, IGNORE} mdio_state_t;
endpackage

// File: rtl/mdio_if.sv
// mdio_if: MDC/MDIO management bus, split into input value, output value and tristate enable.
interface mdio_if;
   logic mdc_i;
   logic mdio_i;
   logic mdio_o;
   logic mdio_t;
   modport master (output mdc_i, output mdio_i, input mdio_o, input mdio_t);
   modport slave (input mdc_i, input mdio_i, output mdio_o, output mdio_t);
endinterface

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: equal-depth synchronisers for MDC/MDIO plus a one-clk MDC rising-edge pulse.
module mdio_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic mdc,
   input  logic mdio,
   output logic mdc_rise,
   output logic mdio_s
);
   logic [SYNC_STAGES-1:0] mdc_q, mdio_q;
   logic mdc_d;
   // Idle-high reset values keep a released bus from producing a spurious rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         mdc_q  <= '1;
         mdio_q <= '1;
         mdc_d  <= 1'b1;
      end else begin
         mdc_q  <= {mdc_q[SYNC_STAGES-2:0], mdc};
         mdio_q <= {mdio_q[SYNC_STAGES-2:0], mdio};
         mdc_d  <= mdc_q[SYNC_STAGES-1];
      end
   end
   assign mdc_rise = mdc_q[SYNC_STAGES-1] & ~mdc_d;
   assign mdio_s   = mdio_q[SYNC_STAGES-1];
endmodule

// File: rtl/mdio_slave.sv
// mdio_slave: clause-22 MDIO responder decoding frames into register read/write strobes.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept ST after a single preamble one.
module mdio_slave
   import mdio_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR     = 5'h00,
   parameter int         PREAMBLE_LEN = 32,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic              clk,
   input  logic              rst,
   mdio_if.slave             bus,
   output logic [4:0]        reg_addr,
   output logic              rd_req,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_valid,
   output logic              busy,
   output logic              frame_err
);
   localparam int PW = $clog2(PREAMBLE_LEN + 1);
   mdio_state_t state;
   logic rise, mdi, rd_d, is_rd, mdio_o, mdio_t, pre_ok;
   logic [4:0] bit_cnt;
   logic [PW-1:0] pre_cnt;
   logic [DATA_W-1:0] rx, tx, rx_n;
   mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .mdc(bus.mdc_i), .mdio(bus.mdio_i), .mdc_rise(rise), .mdio_s(mdi)
   );
   assign rx_n       = {rx[DATA_W-2:0], mdi};
   assign bus.mdio_o = mdio_o;
   assign bus.mdio_t = mdio_t;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign pre_ok = pre_cnt != '0;
`else
   assign pre_ok = pre_cnt == PW'(PREAMBLE_LEN);
`endif
   always_ff @(posedge clk) begin
      rd_req    <= 1'b0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      rd_d      <= rd_req;
      if (rst) begin
         state    <= IDLE;
         mdio_o   <= 1'b1;
         mdio_t   <= 1'b1;
         busy     <= 1'b0;
         reg_addr <= '0;
         wr_data  <= '0;
         pre_cnt  <= '0;
         bit_cnt  <= '0;
         is_rd    <= 1'b0;
         rd_d     <= 1'b0;
         rx       <= '0;
         tx       <= '0;
      end else begin
         if (rd_d) tx <= rd_data;
         if (rise) begin
            rx      <= rx_n;
            bit_cnt <= bit_cnt + 5'd1;
            case (state)
               IDLE: begin
                  if (mdi) pre_cnt <= pre_cnt == PW'(PREAMBLE_LEN) ? pre_cnt : pre_cnt + PW'(1);
                  else begin
                     pre_cnt <= '0;
                     bit_cnt <= 5'd1;
                     busy    <= pre_ok;
                     state   <= pre_ok ? ST2 : IDLE;
                  end
               end
               ST2: begin
                  busy  <= mdi;
                  state <= mdi ? OP : IDLE;
               end
               OP: if (bit_cnt == OP_END) begin
                  is_rd <= rx_n[1:0] == OP_READ;
                  state <= (rx_n[1:0] == OP_READ || rx_n[1:0] == OP_WRITE) ? PHYAD : IGNORE;
               end
               PHYAD: if (bit_cnt == PHYAD_END) state <= rx_n[4:0] == PHY_ADDR ? REGAD : IGNORE;
               REGAD: if (bit_cnt == REGAD_END) begin
                  reg_addr <= rx_n[4:0];
                  rd_req   <= is_rd;
                  state    <= TA;
               end
               TA: begin
                  if (is_rd && bit_cnt == TA_FIRST) begin
                     mdio_o <= 1'b0;
                     mdio_t <= 1'b0;
                  end else if (is_rd) begin
                     mdio_o <= tx[DATA_W-1];
                     tx     <= tx << 1;
                     state  <= DATA;
                  end else if (mdi != (bit_cnt == TA_FIRST)) begin
                     frame_err <= 1'b1;
                     state     <= IGNORE;
                  end else if (bit_cnt != TA_FIRST) state <= DATA;
               end
               DATA: begin
                  if (bit_cnt == FRAME_END) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     mdio_o   <= 1'b1;
                     mdio_t   <= 1'b1;
                     wr_valid <= ~is_rd;
                     if (!is_rd) wr_data <= rx_n;
                  end else if (is_rd) begin
                     mdio_o <= tx[DATA_W-1];
                     tx     <= tx << 1;
                  end
               end
               default: if (bit_cnt == FRAME_END) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: bit-banged MDIO master driving mdio_slave, checked against a frame-level model.
module tb_mdio_slave;
   import mdio_pkg::*;
   localparam logic [4:0] PHY = 5'h00;
   localparam int PRE = 32;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam bit SUP = 1'b1;
`else
   localparam bit SUP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_drv = 1'b1;
   logic [4:0] reg_addr;
   logic rd_req, wr_valid, busy, frame_err;
   logic [15:0] rd_data = 16'h0;
   logic [15:0] wr_data;
   int compared = 0, mismatched = 0;
   int n_rd = 0, n_wr = 0, n_err = 0, n_both = 0;
   logic [4:0] cap_ra = 5'h0;
   logic [15:0] cap_wd = 16'h0;
   mdio_if bus();
   assign bus.mdio_i = bus.mdio_t ? m_drv : bus.mdio_o;
   mdio_slave #(.PHY_ADDR(PHY), .PREAMBLE_LEN(PRE), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .bus(bus), .reg_addr(reg_addr), .rd_req(rd_req), .rd_data(rd_data),
      .wr_data(wr_data), .wr_valid(wr_valid), .busy(busy), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (rd_req) begin
         n_rd++;
         cap_ra = reg_addr;
      end
      if (wr_valid) begin
         n_wr++;
         cap_ra = reg_addr;
         cap_wd = wr_data;
      end
      if (frame_err) n_err++;
      if (rd_req && wr_valid) n_both++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // One MDC period of 8 clks; the master samples the line just before raising MDC.
   task automatic bit_io(input logic b, output logic line, output logic t);
      @(negedge clk);
      bus.mdc_i = 1'b0;
      m_drv = b;
      repeat (4) @(negedge clk);
      line = bus.mdio_i;
      t = bus.mdio_t;
      bus.mdc_i = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                             input logic [15:0] wd, input logic [15:0] rdv, input int abort_at);
      logic [31:0] f;
      logic [15:0] got;
      logic line, t, bmid;
      bit acc, adr, is_rd, is_wr;
      int drv, r0, w0, e0;
      f = {st, op, phy, ra, ta, wd};
      rd_data = rdv;
      r0 = n_rd; w0 = n_wr; e0 = n_err;
      drv = 0; got = 16'h0; bmid = 1'b0;
      for (int i = 0; i < pre; i++) bit_io(1'b1, line, t);
      for (int i = 0; i < 32; i++) begin
         if (i == abort_at) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_mdio_t", 32'(bus.mdio_t), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            m_drv = 1'b1;
            return;
         end
         bit_io((op == OP_READ && i >= 14) ? 1'b1 : f[31-i], line, t);
         if (!t) drv++;
         if (i >= 16) got = {got[14:0], line};
         if (i == 20) bmid = busy;
      end
      repeat (2) @(negedge clk);
      acc   = st == ST && (SUP ? pre >= 1 : pre >= PRE);
      adr   = acc && phy == PHY && (op == OP_READ || op == OP_WRITE);
      is_rd = adr && op == OP_READ;
      is_wr = adr && op == OP_WRITE;
      check("rd_req_cnt", 32'(n_rd - r0), 32'(is_rd));
      check("wr_valid_cnt", 32'(n_wr - w0), 32'(is_wr && ta == 2'b10));
      check("frame_err_cnt", 32'(n_err - e0), 32'(is_wr && ta != 2'b10));
      check("drive_bits", 32'(drv), is_rd ? 32'd17 : 32'd0);
      check("busy_mid", 32'(bmid), 32'(acc));
      check("busy_end", 32'(busy), 32'd0);
      check("mdio_t_end", 32'(bus.mdio_t), 32'd1);
      if (adr) check("reg_addr", 32'(reg_addr), 32'(ra));
      if (is_rd) begin
         check("rd_data_out", 32'(got), 32'(rdv));
         check("rd_req_addr", 32'(cap_ra), 32'(ra));
      end
      if (is_wr && ta == 2'b10) begin
         check("wr_data", 32'(cap_wd), 32'(wd));
         check("wr_addr", 32'(cap_ra), 32'(ra));
      end
   endtask
   initial begin
      logic [1:0] op, ta;
      logic [4:0] phy;
      bus.mdc_i = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_mdio_t", 32'(bus.mdio_t), 32'd1);
      check("reset_mdio_o", 32'(bus.mdio_o), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_strobes", 32'({rd_req, wr_valid, frame_err}), 32'd0);
      check("reset_reg_addr", 32'(reg_addr), 32'd0);
      check("reset_wr_data", 32'(wr_data), 32'd0);
      send_frame(PRE, ST, OP_WRITE, 5'h00, 5'h09, 2'b10, 16'h0000, 16'h0000, -1);
      send_frame(PRE, ST, OP_WRITE, 5'h00, 5'h00, 2'b10, 16'h1340, 16'h0000, -1);
      send_frame(PRE, ST, OP_READ, 5'h00, 5'h01, 2'b10, 16'h0000, 16'h796D, -1);
      send_frame(PRE, ST, OP_READ, 5'h05, 5'h03, 2'b10, 16'h0000, 16'hA5A5, -1);
      send_frame(PRE, ST, OP_WRITE, 5'h05, 5'h04, 2'b10, 16'h1234, 16'h0000, -1);
      send_frame(16, ST, OP_WRITE, 5'h00, 5'h07, 2'b10, 16'hBEEF, 16'h0000, -1);
      send_frame(PRE, 2'b00, 2'b00, 5'h00, 5'h00, 2'b00, 16'h0000, 16'h0000, -1);
      send_frame(PRE, ST, OP_WRITE, 5'h00, 5'h05, 2'b11, 16'h5555, 16'h0000, -1);
      send_frame(PRE, ST, OP_READ, 5'h00, 5'h02, 2'b10, 16'h0000, 16'hC3C3, 24);
      repeat (20) @(negedge clk);
      send_frame(PRE, ST, OP_READ, 5'h00, 5'h02, 2'b10, 16'h0000, 16'hC3C3, -1);
      for (int n = 0; n < 30; n++) begin
         op  = 2'($urandom);
         phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY;
         ta  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         send_frame(PRE + int'($urandom_range(0, 4)), ST, op, phy, 5'($urandom), ta,
                    16'($urandom), 16'($urandom), -1);
      end
      check("strobe_overlap", 32'(n_both), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
